// File: rtl/p3p_pkg.sv
// Shared p3p datapath types: the signed sample word, SRAM geometry and the
// arbiter's state encoding.
package p3p_pkg;
  typedef logic signed [15:0] num;

  localparam int SRAM_ADDR_W = 21;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } arb_state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side bus of the SRAM arbiter: per-requester level requests in,
// one-hot grant/completion and shared read data out.
interface sram_arbiter_if import p3p_pkg::*; #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = SRAM_ADDR_W
);
  logic [N_REQ-1:0]             req_read;
  logic [N_REQ-1:0]             req_write;
  logic [N_REQ-1:0][ADDR_W-1:0] req_addr;
  num   [N_REQ-1:0]             req_wdata;
  logic [N_REQ-1:0]             grant;
  logic [N_REQ-1:0]             req_done;
  num                           req_rdata;

  modport master (
    output req_read, req_write, req_addr, req_wdata,
    input  grant, req_done, req_rdata
  );

  modport slave (
    input  req_read, req_write, req_addr, req_wdata,
    output grant, req_done, req_rdata
  );
endinterface

// File: rtl/rr_select.sv
// Combinational round-robin pick: the first active request after `last`,
// wrapping modulo N_REQ, as one-hot, index and valid flag.
module rr_select import p3p_pkg::*; #(
  parameter  int N_REQ = 2,
  localparam int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [N_REQ-1:0] winner,
  output logic [IDX_W-1:0] winner_idx,
  output logic             valid
);
  logic [IDX_W-1:0] pos;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    valid      = 1'b0;
    pos        = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      pos = IDX_W'((int'(last) + k) % N_REQ);
      if (!valid && req[pos]) begin
        winner[pos] = 1'b1;
        winner_idx  = pos;
        valid       = 1'b1;
      end
    end
  end
endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter serialising single-word requester transactions onto the
// one SRAM access port; one transaction in flight, never pipelined.
module sram_arbiter import p3p_pkg::*; #(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = SRAM_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  sram_arbiter_if.slave     bus,
  output logic [ADDR_W-1:0] data_addr,
  output num                data_out,
  output logic              read_data,
  output logic              write_data,
  input  num                data_in,
  input  logic              sram_ready,
  input  logic              sram_idle
);
  localparam int IDX_W = idx_w(N_REQ);

  arb_state_t       state;
  logic [IDX_W-1:0] last;
  logic             is_read;
  logic [N_REQ-1:0] req_any;
  logic [N_REQ-1:0] pick;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;

  assign req_any = bus.req_read | bus.req_write;

  rr_select #(.N_REQ(N_REQ)) u_sel (
    .req        (req_any),
    .last       (last),
    .winner     (pick),
    .winner_idx (pick_idx),
    .valid      (pick_vld)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      bus.grant     <= '0;
      bus.req_done  <= '0;
      bus.req_rdata <= '0;
      read_data     <= 1'b0;
      write_data    <= 1'b0;
      data_addr     <= '0;
      data_out      <= '0;
      is_read       <= 1'b0;
      last          <= IDX_W'(N_REQ - 1);
    end else begin
      case (state)
        ST_IDLE: begin
          if (sram_idle && pick_vld) begin
            // A requester raising both directions is served as a read.
            is_read    <= bus.req_read[pick_idx];
            read_data  <= bus.req_read[pick_idx];
            write_data <= ~bus.req_read[pick_idx];
            data_addr  <= bus.req_addr[pick_idx];
            data_out   <= bus.req_wdata[pick_idx];
            bus.grant  <= pick;
            last       <= pick_idx;
            state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          read_data  <= 1'b0;
          write_data <= 1'b0;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (sram_ready) begin
            if (is_read) bus.req_rdata <= data_in;
            bus.req_done <= bus.grant;
            state        <= ST_DONE;
          end
        end
        ST_DONE: begin
          bus.req_done <= '0;
          bus.grant    <= '0;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios and randomized two-requester
// traffic, checked each cycle against a transaction-level reference model.
module tb_sram_arbiter;
  import p3p_pkg::*;

  localparam int N  = 2;
  localparam int AW = 21;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] data_addr;
  num            data_out;
  num            data_in;
  logic          read_data, write_data, sram_ready, sram_idle;

  sram_arbiter_if #(.N_REQ(N), .ADDR_W(AW)) bus ();

  sram_arbiter #(.N_REQ(N), .ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .data_addr  (data_addr),
    .data_out   (data_out),
    .read_data  (read_data),
    .write_data (write_data),
    .data_in    (data_in),
    .sram_ready (sram_ready),
    .sram_idle  (sram_idle)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Two views of memory: what the SRAM stub holds, and what the model expects.
  num sram_mem [int];
  num ref_mem  [int];

  function automatic num init_val(input int a);
    return num'(a * 97 + 785);
  endfunction

  function automatic num sram_rd(input int a);
    return sram_mem.exists(a) ? sram_mem[a] : init_val(a);
  endfunction

  function automatic num ref_rd(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // SRAM stub and requester state
  bit sram_pending = 0;
  bit sram_rd_op   = 0;
  int sram_cnt     = 0;
  int sram_addr    = 0;
  bit idle_en      = 1;
  int fixed_lat    = -1;
  bit active  [N];
  bit auto_en [N];
  int done_cnt[N];
  int auto_div = 3;

  // Observations
  int            ecyc = 0;
  int            rd_strobes, wr_strobes;
  logic [AW-1:0] strobe_addr;
  num            strobe_data;
  logic [N-1:0]  grant_seen;
  logic [N-1:0]  last_done_vec;
  num            done_rdata;
  int            last_done_cyc = -1000;
  int            done_total = 0;
  int            done_log[$];
  int            gaps[$];

  task automatic clear_stats();
    rd_strobes = 0; wr_strobes = 0; grant_seen = '0; last_done_vec = '0;
    done_log.delete(); gaps.delete(); last_done_cyc = -1000;
  endtask

  task automatic start_req(input int i, input bit rd, input bit wr,
                           input logic [AW-1:0] a, input num wd);
    active[i] = 1'b1;
    bus.req_read[i]  = rd;
    bus.req_write[i] = wr;
    bus.req_addr[i]  = a;
    bus.req_wdata[i] = wd;
  endtask

  task automatic drop_req(input int i);
    active[i] = 1'b0;
    bus.req_read[i]  = 1'b0;
    bus.req_write[i] = 1'b0;
    bus.req_addr[i]  = AW'($urandom_range(0, 15));
    bus.req_wdata[i] = num'($urandom);
  endtask

  task automatic start_random(input int i);
    int op;
    op = int'($urandom_range(0, 2));
    start_req(i, op != 1, op != 0, AW'($urandom_range(0, 15)), num'($urandom));
  endtask

  task automatic env_update();
    sram_ready = 1'b0;
    data_in    = num'($urandom);
    if (sram_pending) begin
      if (sram_cnt == 0) begin
        sram_ready   = 1'b1;
        sram_pending = 1'b0;
        if (sram_rd_op) data_in = sram_rd(sram_addr);
      end else begin
        sram_cnt--;
      end
    end
    if (read_data === 1'b1 || write_data === 1'b1) begin
      sram_pending = 1'b1;
      sram_rd_op   = read_data;
      sram_addr    = int'(data_addr);
      sram_cnt     = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      if (write_data) sram_mem[int'(data_addr)] = data_out;
      if (read_data) rd_strobes++;
      if (write_data) wr_strobes++;
      strobe_addr = data_addr;
      strobe_data = data_out;
      gaps.push_back(ecyc - last_done_cyc);
    end
    sram_idle = idle_en && !sram_pending;
    grant_seen |= bus.grant;
    if (bus.req_done != '0) begin
      done_log.push_back(bus.req_done[1] ? 1 : 0);
      last_done_vec = bus.req_done;
      done_rdata    = bus.req_rdata;
      last_done_cyc = ecyc;
      done_total++;
    end
    for (int i = 0; i < N; i++) begin
      if (active[i] && bus.req_done[i]) begin
        drop_req(i);
        done_cnt[i]++;
      end else if (!active[i] && auto_en[i] && $urandom_range(0, auto_div - 1) == 0) begin
        start_random(i);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    ecyc++;
    env_update();
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    sram_pending = 1'b0;
    sram_ready   = 1'b0;
    repeat (cycles) step();
    reset = 1'b0;
  endtask

  task automatic wait_done(input int i, input int maxc);
    int start;
    bit ok;
    start = done_cnt[i];
    ok = 1'b0;
    for (int k = 0; k < maxc; k++) begin
      step();
      if (done_cnt[i] != start) begin
        ok = 1'b1;
        break;
      end
    end
    chk($sformatf("done_r%0d_in_time", i), 32'(ok), 32'd1);
    step();
  endtask

  // Reference model: one transaction at a time, described by the cycle it
  // was granted, the cycle its strobe appears and the cycle it completes.
  int            cyc     = 0;
  int            m_owner = -1;
  int            m_issue = -1;
  int            m_done  = -1;
  int            m_last  = N - 1;
  bit            m_rd    = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  num            m_wdata = '0;
  num            m_rdata = '0;
  bit            chk_en  = 1'b0;

  task automatic model_step();
    logic [N-1:0] reqv;
    int w;
    if (reset !== 1'b0) begin
      m_owner = -1; m_issue = -1; m_done = -1; m_last = N - 1;
      m_addr = '0; m_wdata = '0; m_rdata = '0; m_rd = 1'b0;
      return;
    end
    if (m_owner < 0) begin
      reqv = bus.req_read | bus.req_write;
      if (sram_idle && reqv != '0) begin
        w = m_last;
        for (int k = 1; k <= N; k++) begin
          w = (m_last + k) % N;
          if (reqv[w]) break;
        end
        m_owner = w;
        m_last  = w;
        m_rd    = bus.req_read[w];
        m_addr  = bus.req_addr[w];
        m_wdata = bus.req_wdata[w];
        m_issue = cyc + 1;
        m_done  = -1;
        if (!m_rd) ref_mem[int'(m_addr)] = m_wdata;
      end
    end else if (cyc == m_done) begin
      m_owner = -1;
    end else if (m_done < 0 && cyc > m_issue && sram_ready) begin
      m_done = cyc + 1;
      if (m_rd) m_rdata = ref_rd(int'(m_addr));
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("grant", 32'(bus.grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("req_done", 32'(bus.req_done),
            (m_owner >= 0 && cyc == m_done) ? (32'd1 << m_owner) : 32'd0);
        chk("read_data", 32'(read_data), 32'(cyc == m_issue && m_rd));
        chk("write_data", 32'(write_data), 32'(cyc == m_issue && !m_rd));
        chk("data_addr", 32'(data_addr), 32'(m_addr));
        chk("data_out", 32'($unsigned(data_out)), 32'($unsigned(m_wdata)));
        chk("req_rdata", 32'($unsigned(bus.req_rdata)), 32'($unsigned(m_rdata)));
      end
      model_step();
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit bad;
    bit found;
    int dc1;

    reset = 1'b1;
    sram_ready = 1'b0;
    sram_idle  = 1'b1;
    data_in    = '0;
    bus.req_read  = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < N; i++) begin
      active[i] = 1'b0; auto_en[i] = 1'b0; done_cnt[i] = 0;
    end
    do_reset(3);
    chk_en = 1'b1;

    chk("rst_grant", 32'(bus.grant), 32'd0);
    chk("rst_req_done", 32'(bus.req_done), 32'd0);
    chk("rst_strobes", 32'({read_data, write_data}), 32'd0);
    chk("rst_data_addr", 32'(data_addr), 32'd0);
    chk("rst_req_rdata", 32'($unsigned(bus.req_rdata)), 32'd0);

    // Single read by requester 0
    clear_stats();
    sram_mem[16] = num'(16'h1234);
    ref_mem[16]  = num'(16'h1234);
    start_req(0, 1'b1, 1'b0, AW'(16), '0);
    wait_done(0, 40);
    chk("rd1_strobes", 32'(rd_strobes), 32'd1);
    chk("rd1_no_write", 32'(wr_strobes), 32'd0);
    chk("rd1_addr", 32'(strobe_addr), 32'h10);
    chk("rd1_done_vec", 32'(last_done_vec), 32'b01);
    chk("rd1_rdata", 32'($unsigned(done_rdata)), 32'h1234);
    chk("rd1_grant1_quiet", 32'(grant_seen[1]), 32'd0);

    // Write then read back by requester 1
    clear_stats();
    start_req(1, 1'b0, 1'b1, AW'(32), num'(16'h8008));
    wait_done(1, 40);
    chk("wr_strobes", 32'(wr_strobes), 32'd1);
    chk("wr_data", 32'($unsigned(strobe_data)), 32'h8008);
    chk("wr_addr", 32'(strobe_addr), 32'h20);
    start_req(1, 1'b1, 1'b0, AW'(32), num'(16'h0055));
    wait_done(1, 40);
    chk("rb_done_vec", 32'(last_done_vec), 32'b10);
    chk("rb_rdata", 32'($unsigned(done_rdata)), 32'h8008);

    // Contention from reset: alternating grants, one idle cycle in between
    do_reset(2);
    clear_stats();
    auto_div = 1;
    auto_en[0] = 1'b1; auto_en[1] = 1'b1;
    for (int k = 0; k < 100 && done_log.size() < 4; k++) step();
    auto_en[0] = 1'b0; auto_en[1] = 1'b0;
    chk("cont_count", 32'(done_log.size() >= 4), 32'd1);
    for (int k = 0; k < 4; k++)
      chk($sformatf("cont_owner%0d", k), (done_log.size() > k) ? 32'(done_log[k]) : 32'hFFFF, 32'(k % 2));
    for (int k = 1; k < 4; k++)
      chk($sformatf("cont_gap%0d", k), (gaps.size() > k) ? 32'(gaps[k]) : 32'hFFFF, 32'd2);
    for (int k = 0; k < 60 && (active[0] || active[1]); k++) step();
    chk("cont_drained", 32'(active[0] || active[1]), 32'd0);
    step();

    // Request held while the SRAM reports busy
    idle_en = 1'b0;
    sram_idle = 1'b0;
    start_req(0, 1'b1, 1'b0, AW'(3), '0);
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (read_data !== 1'b0 || write_data !== 1'b0 || bus.grant !== '0) bad = 1'b1;
    end
    chk("busy_hold_quiet", 32'(bad), 32'd0);
    idle_en = 1'b1;
    sram_idle = 1'b1;
    step();
    chk("busy_release_strobe", 32'(read_data), 32'd1);
    chk("busy_release_grant", 32'(bus.grant), 32'b01);
    wait_done(0, 40);

    // Read and write raised together: served as a read
    clear_stats();
    sram_mem[5] = num'(16'h0BAD);
    ref_mem[5]  = num'(16'h0BAD);
    start_req(0, 1'b1, 1'b1, AW'(5), num'(16'h7777));
    wait_done(0, 40);
    chk("both_rd_strobes", 32'(rd_strobes), 32'd1);
    chk("both_wr_strobes", 32'(wr_strobes), 32'd0);
    chk("both_rdata", 32'($unsigned(done_rdata)), 32'h0BAD);

    // Reset while waiting on the SRAM
    fixed_lat = 8;
    start_req(1, 1'b1, 1'b0, AW'(7), '0);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (bus.grant[1] === 1'b1 && read_data === 1'b0 && write_data === 1'b0) found = 1'b1;
    end
    chk("mid_wait_reached", 32'(found), 32'd1);
    reset = 1'b1;
    sram_pending = 1'b0;
    sram_ready = 1'b0;
    dc1 = done_cnt[1];
    step();
    reset = 1'b0;
    fixed_lat = -1;
    chk("mrst_grant", 32'(bus.grant), 32'd0);
    chk("mrst_req_done", 32'(bus.req_done), 32'd0);
    chk("mrst_strobes", 32'({read_data, write_data}), 32'd0);
    chk("mrst_data_addr", 32'(data_addr), 32'd0);
    chk("mrst_data_out", 32'($unsigned(data_out)), 32'd0);
    chk("mrst_req_rdata", 32'($unsigned(bus.req_rdata)), 32'd0);
    clear_stats();
    start_req(0, 1'b1, 1'b0, AW'(3), '0);
    wait_done(0, 40);
    chk("mrst_first_owner", (done_log.size() > 0) ? 32'(done_log[0]) : 32'hFFFF, 32'd0);
    chk("mrst_r1_not_done", 32'(done_cnt[1]), 32'(dc1));
    wait_done(1, 40);

    // Randomized traffic
    done_total = 0;
    auto_div = 3;
    auto_en[0] = 1'b1; auto_en[1] = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      idle_en = ($urandom_range(0, 7) != 0);
      step();
    end
    auto_en[0] = 1'b0; auto_en[1] = 1'b0;
    idle_en = 1'b1;
    for (int k = 0; k < 80 && (active[0] || active[1]); k++) step();
    chk("rand_drained", 32'(active[0] || active[1]), 32'd0);
    chk("rand_progress", 32'(done_total > 100), 32'd1);
    repeat (3) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Round-robin arbiter sharing the single `sram` access module between `N_REQ` requesters, e.g. `send` reading senone scores and a UART-fed loader writing vectors. It sits between the requesters and `sram`, serialises their single-word read/write transactions, and returns read data and a completion pulse to the owning requester only. It performs exactly one `sram` transaction at a time and never pipelines.

## Interface
- `N_REQ`, 2, number of requesters (2..8)
- `ADDR_W`, 21, SRAM word-address width
- `clk` in 1, system clock
- `reset` in 1, synchronous, active-high
- `req_read` in `N_REQ`, per-requester read request; level, held until that requester's `req_done`
- `req_write` in `N_REQ`, per-requester write request; level, same rule
- `req_addr` in `N_REQ` x `ADDR_W`, per-requester address, stable while requesting
- `req_wdata` in `N_REQ` x `num`, per-requester write data
- `grant` out `N_REQ`, one-hot owner of the transaction in flight; 0 when idle
- `req_done` out `N_REQ`, one-cycle pulse on the owner's bit at completion
- `req_rdata` out `num`, read data shared by all requesters, valid while `req_done` is high
- `data_addr` out `ADDR_W`, to `sram.data_addr`
- `data_out` out `num`, to `sram.data_in`
- `read_data` out 1, one-cycle read strobe to `sram`
- `write_data` out 1, one-cycle write strobe to `sram`
- `data_in` in `num`, from `sram.data_out`
- `sram_ready` in 1, one-cycle pulse from `sram`: read data valid or write complete
- `sram_idle` in 1, `sram` can accept a strobe

## Operation
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: if `sram_idle` and any request is active, select the winner, register its address, write data and direction, set `grant`, then go to ISSUE. With no request, or `sram_idle` low, stay in IDLE.
- Arbitration: round-robin. Search starts at `last+1` and wraps modulo `N_REQ`. `last` updates to the winner. `last` resets to `N_REQ-1`, so requester 0 wins first.
- A requester asserting both `req_read` and `req_write` is treated as a read.
- ISSUE: drive `read_data` or `write_data` for exactly one cycle, with `data_addr` and `data_out` taken from the registers. Then go to WAIT.
- WAIT: hold `grant`. On `sram_ready`, capture `data_in` into `req_rdata` (reads only; writes leave it unchanged), then go to DONE.
- DONE: pulse `req_done[winner]` for one cycle and clear `grant`. Then go to IDLE.
- Request changes during ISSUE, WAIT or DONE are ignored. Requests are sampled only in IDLE.
- Reset at any point (mid-transaction included) forces: state IDLE, `grant`=0, `req_done`=0, `read_data`=`write_data`=0, `data_addr`=0, `data_out`=0, `req_rdata`=0, `last`=`N_REQ-1`. An in-flight transaction is dropped; `sram` is reset in the same cycle.

## Timing
- Request seen in IDLE at cycle t: `grant` at t+1, strobe at t+1 (ISSUE), WAIT from t+2.
- `sram_ready` at cycle r: `req_done` and valid `req_rdata` at r+1.
- Minimum turnaround is 4 cycles plus the `sram` latency.
- A requester sees `req_done` at cycle d and must drop its request by the edge ending cycle d. IDLE at d+1 therefore never re-grants a completed request.
- Back-to-back: when the next requester is already waiting, IDLE at d+1 grants it, giving one idle cycle between transactions.
- Strobes never overlap, and only one bit of `grant` or `req_done` is ever high.

## Structure
- Shared package `p3p_pkg` holds `typedef logic signed [15:0] num` and the SRAM address width constant. No local redefinition of `num`.
- One natural sub-module: `rr_select`, combinational round-robin winner from the request vector and `last`, outputting one-hot winner and a valid flag.

## Test plan
- Single read: requester 0 reads addr 0x00010, which the model holds as 0x1234. Expect one `read_data` strobe with `data_addr`=0x00010, then `req_done`=2'b01 with `req_rdata`=0x1234. `grant[1]` never rises.
- Write then read: requester 1 writes 0x8008 to 0x00020, then reads it back. Expect `write_data` with `data_out`=0x8008, then a read returning 0x8008 on `req_done`=2'b10.
- Contention: both requesters request continuously from reset. Grants must alternate 0,1,0,1 across four transactions, with exactly one idle cycle between DONE and the next ISSUE.
- `sram_idle` low: a request is held while `sram_idle`=0 for 10 cycles. Expect no strobe and `grant`=0 until `sram_idle` rises. The strobe follows 1 cycle later.
- Reset mid-WAIT: assert `reset` for one cycle while in WAIT. All outputs are 0 the next cycle, no `req_done` pulse occurs, and the next grant goes to requester 0.
- Read+write together: requester 0 asserts both. Only `read_data` strobes and `write_data` stays 0.
